// File: rtl/capture_ctrl_if.sv
// Acquisition-side bundle for capture_ctrl: ADC stream, trigger setup, RAM write port and frame handoff.
// master = the capture controller, slave = the environment (ADC, RAM, display reader).
interface capture_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic              sample_valid;
    logic [DATA_W-1:0] data_input;
    logic [1:0]        mode;
    logic              edge_sel;
    logic [DATA_W-1:0] trig_level;
    logic [ADDR_W-1:0] pretrig;
    logic              arm;
    logic              frame_ack;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              trig_forced;
    logic              busy;

    modport master (
        input  sample_valid, data_input, mode, edge_sel, trig_level, pretrig, arm, frame_ack,
        output wr_en, wr_addr, wr_data, frame_ready, start_addr, trig_addr, trig_forced, busy
    );

    modport slave (
        output sample_valid, data_input, mode, edge_sel, trig_level, pretrig, arm, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_ready, start_addr, trig_addr, trig_forced, busy
    );
endinterface

// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer: writes a pre/post-trigger window into a circular sample RAM, 1-cycle write latency.
// No backpressure: every sample_valid strobe is written or dropped by state; TRIG_HOLDOFF_EN adds a post-ack holdoff.
module capture_ctrl #(
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 8,
    parameter int HYST         = 8,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int HOLDOFF      = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    capture_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(AUTO_TIMEOUT + HOLDOFF + (1 << ADDR_W)) + 1;

    localparam logic [1:0] MODE_STOP   = 2'b00;
    localparam logic [1:0] MODE_NORM   = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);
    localparam logic [DATA_W:0] FULL_X = {1'b0, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_DONE
`ifdef TRIG_HOLDOFF_EN
        , S_HOLDOFF
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_below, w_below_nxt;
    logic              w_trig, w_forced, w_capturing;

    logic [ADDR_W-1:0] r_ptr, r_wr_addr, r_start_addr, r_trig_addr, w_post_len;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en, r_trig_forced;

    logic [DATA_W:0]   w_smp, w_lvl, w_lo, w_hi;
    logic              w_arm_cond, w_hit, w_edge;

    // Thresholds are computed one bit wider so level +/- HYST saturates instead of wrapping.
    assign w_smp      = {1'b0, bus.data_input};
    assign w_lvl      = {1'b0, bus.trig_level};
    assign w_lo       = (w_lvl >= HYST_X) ? (w_lvl - HYST_X) : '0;
    assign w_hi       = ((w_lvl + HYST_X) >= FULL_X) ? FULL_X : (w_lvl + HYST_X);
    assign w_arm_cond = bus.edge_sel ? (w_smp >= w_hi) : (w_smp <= w_lo);
    assign w_hit      = bus.edge_sel ? (w_smp <= w_lvl) : (w_smp >= w_lvl);
    assign w_edge     = r_below && w_hit;

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_post_len  = {ADDR_W{1'b1}} - bus.pretrig;
    assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_below_nxt = r_below;
        w_trig      = 1'b0;
        w_forced    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.mode == MODE_NORM || bus.mode == MODE_AUTO ||
                    (bus.mode == MODE_SINGLE && bus.arm))
                    w_state_nxt = S_PRETRIG;
            end
            S_PRETRIG: begin
                if (bus.sample_valid)
                    w_cnt_nxt = w_cnt_inc;
                if (bus.pretrig == '0 ||
                    (bus.sample_valid && w_cnt_inc >= CNT_W'(bus.pretrig)))
                    w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (bus.sample_valid) begin
                    if (bus.mode == MODE_AUTO)
                        w_cnt_nxt = w_cnt_inc;
                    // A real edge wins over a timeout landing on the same sample.
                    if (w_edge) begin
                        w_trig = 1'b1;
                    end else if (bus.mode == MODE_AUTO && w_cnt_inc >= CNT_W'(AUTO_TIMEOUT)) begin
                        w_trig   = 1'b1;
                        w_forced = 1'b1;
                    end
                    if (w_edge)
                        w_below_nxt = 1'b0;
                    else if (w_arm_cond)
                        w_below_nxt = 1'b1;
                    // pretrig = max leaves no post samples; skipping POST keeps the oldest sample intact.
                    if (w_trig)
                        w_state_nxt = (w_post_len == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (bus.sample_valid) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= CNT_W'(w_post_len))
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.frame_ack) begin
                    if (bus.mode == MODE_NORM || bus.mode == MODE_AUTO)
`ifdef TRIG_HOLDOFF_EN
                        w_state_nxt = S_HOLDOFF;
`else
                        w_state_nxt = S_PRETRIG;
`endif
                    else
                        w_state_nxt = S_IDLE;
                end
            end
`ifdef TRIG_HOLDOFF_EN
            S_HOLDOFF: begin
                if (bus.sample_valid) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= CNT_W'(HOLDOFF))
                        w_state_nxt = S_PRETRIG;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        if (bus.mode == MODE_STOP && r_state != S_DONE)
            w_state_nxt = S_IDLE;
        if (w_state_nxt != r_state)
            w_cnt_nxt = '0;
        if (w_state_nxt == S_PRETRIG && r_state != S_PRETRIG)
            w_below_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_below       <= 1'b0;
            r_ptr         <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_start_addr  <= '0;
            r_trig_addr   <= '0;
            r_trig_forced <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_below <= w_below_nxt;
            r_wr_en <= bus.sample_valid && w_capturing;
            if (bus.sample_valid && w_capturing) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= bus.data_input;
                r_ptr     <= r_ptr + ADDR_W'(1);
            end
            if (w_trig && w_state_nxt != S_IDLE) begin
                r_trig_addr   <= r_ptr;
                r_start_addr  <= r_ptr - bus.pretrig;
                r_trig_forced <= w_forced;
            end
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.frame_ready = (r_state == S_DONE);
    assign bus.start_addr  = r_start_addr;
    assign bus.trig_addr   = r_trig_addr;
    assign bus.trig_forced = r_trig_forced;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
